battle_controller: RTL and testbench

- Top-level turn sequencer and initiator of the phase-handshake protocol.
- Drives the 4-bit phase code and turn index consumed by the enemy-phase block, and waits on that block's busy/finished handshake.
- Accumulates damage pulses into player HP; applies player attacks to enemy HP.
- Decides game over and victory; sits between the camera/button inputs and all phase blocks.

---
 rtl/battle_pkg.sv | 24 ++
 rtl/battle_controller_rise_detect.sv | 26 ++
 rtl/battle_controller.sv | 162 ++++++++++++++++
 tb/tb_battle_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// battle_pkg: codes and helpers shared by the battle controller and every
// phase block, so the 4-bit phase encoding is defined in exactly one place.
//   phase_t : the six phase codes driven on state_out
//   HP_W    : width of all hit-point values
//   sat_sub : subtraction clamped at zero, used for all HP damage
package battle_pkg;

  localparam int HP_W = 8;

  typedef enum logic [3:0] {
    PH_TITLE  = 4'b0000,
    PH_MENU   = 4'b0001,
    PH_ATTACK = 4'b0010,
    PH_ENEMY  = 4'b1000,
    PH_LOSE   = 4'b1100,
    PH_WIN    = 4'b1110
  } phase_t;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

endpackage

// File: rtl/battle_controller_rise_detect.sv
// rise_detect: 1-bit rising-edge detector. The previous input value is
// registered; rise is high for the cycle in which d is seen high after
// having been low on the previous clock.
//   clk  : system clock
//   rst  : synchronous active-high reset (clears the history register)
//   d    : level input (already debounced)
//   rise : one-cycle rising-edge indication
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/battle_controller.sv
// battle_controller: top-level turn sequencer. Walks TITLE -> MENU ->
// ATTACK -> ENEMY -> MENU ... and ends in LOSE or WIN. Drives the phase
// code and turn index to the enemy-phase block and reacts to its
// busy/finished/damage signals.
// Optional build macro: BATTLE_IFRAME_EN (adds a post-hit invulnerability
// window of IFRAME_CYCLES cycles during which damage edges are ignored).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start_in            : start/restart button (level, edge-detected here)
//   confirm_in          : menu confirm button (level, edge-detected here)
//   select_in           : menu choice, 0 = FIGHT, 1 = SPARE
//   attack_done_in      : pulse, attack minigame ended
//   attack_hit_in       : qualifies attack_done_in, 1 = attack landed
//   enemy_busy_in       : enemy-phase block still running
//   enemy_finished_in   : pulse, enemy phase complete
//   damage_in           : damage level from enemy-phase block
//   state_out           : current phase code
//   turn_out            : pattern/turn index, wraps at NUM_TURNS
//   player_hp_out       : player hit points
//   enemy_hp_out        : enemy hit points
//   game_over_out       : high in LOSE
//   win_out             : high in WIN
module battle_controller
  import battle_pkg::*;
#(
  parameter int          PLAYER_HP_MAX  = 20,
  parameter int          ENEMY_HP_MAX   = 30,
  parameter int          HIT_DMG        = 4,
  parameter int          ATTACK_DMG     = 5,
  parameter int          NUM_TURNS      = 10,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd650_000_000
`ifdef BATTLE_IFRAME_EN
  ,
  parameter logic [31:0] IFRAME_CYCLES  = 32'd32_500_000
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic            confirm_in,
  input  logic            select_in,
  input  logic            attack_done_in,
  input  logic            attack_hit_in,
  input  logic            enemy_busy_in,
  input  logic            enemy_finished_in,
  input  logic            damage_in,
  output logic [3:0]      state_out,
  output logic [3:0]      turn_out,
  output logic [HP_W-1:0] player_hp_out,
  output logic [HP_W-1:0] enemy_hp_out,
  output logic            game_over_out,
  output logic            win_out
);

  localparam logic [HP_W-1:0] PLAYER_MAX = HP_W'(PLAYER_HP_MAX);
  localparam logic [HP_W-1:0] ENEMY_MAX  = HP_W'(ENEMY_HP_MAX);
  localparam logic [HP_W-1:0] HIT        = HP_W'(HIT_DMG);
  localparam logic [HP_W-1:0] ATK        = HP_W'(ATTACK_DMG);
  localparam logic [3:0]      LAST_TURN  = 4'(NUM_TURNS - 1);

  phase_t            state, state_next;
  logic [HP_W-1:0]   php_next, ehp_next, hit_hp;
  logic [3:0]        turn_next;
  logic [31:0]       watchdog, wd_next;
  logic              start_rise, confirm_rise, damage_rise;
  logic              iframe_ok, hit_accept;

  rise_detect u_start   (.clk(clk), .rst(rst), .d(start_in),   .rise(start_rise));
  rise_detect u_confirm (.clk(clk), .rst(rst), .d(confirm_in), .rise(confirm_rise));
  rise_detect u_damage  (.clk(clk), .rst(rst), .d(damage_in),  .rise(damage_rise));

`ifdef BATTLE_IFRAME_EN
  logic [31:0] iframe_cnt;

  assign iframe_ok = (iframe_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)
      iframe_cnt <= '0;
    else if (state != PH_ENEMY || state_next != PH_ENEMY)
      iframe_cnt <= '0;
    else if (hit_accept)
      iframe_cnt <= IFRAME_CYCLES - 32'd1;
    else if (iframe_cnt != '0)
      iframe_cnt <= iframe_cnt - 32'd1;
  end
`else
  assign iframe_ok = 1'b1;
`endif

  assign hit_accept = (state == PH_ENEMY) && damage_rise && iframe_ok;
  assign hit_hp     = sat_sub(player_hp_out, HIT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    php_next   = player_hp_out;
    ehp_next   = enemy_hp_out;
    turn_next  = turn_out;
    wd_next    = '0;
    unique case (state)
      PH_TITLE: begin
        if (start_rise) begin
          state_next = PH_MENU;
          php_next   = PLAYER_MAX;
          ehp_next   = ENEMY_MAX;
          turn_next  = '0;
        end
      end
      PH_MENU: begin
        if (confirm_rise) state_next = select_in ? PH_WIN : PH_ATTACK;
      end
      PH_ATTACK: begin
        if (attack_done_in) begin
          if (attack_hit_in) ehp_next = sat_sub(enemy_hp_out, ATK);
          state_next = (ehp_next == '0) ? PH_WIN : PH_ENEMY;
        end
      end
      PH_ENEMY: begin
        wd_next = watchdog + 32'd1;
        if (hit_accept) php_next = hit_hp;
        // A lethal hit wins over a same-cycle finish or timeout.
        if (hit_accept && hit_hp == '0) begin
          state_next = PH_LOSE;
        end else if (enemy_finished_in ||
                     (watchdog == TIMEOUT_CYCLES - 32'd1 && enemy_busy_in)) begin
          state_next = PH_MENU;
          turn_next  = (turn_out == LAST_TURN) ? 4'd0 : turn_out + 4'd1;
          wd_next    = '0;
        end
      end
      PH_LOSE, PH_WIN: begin
        if (start_rise) state_next = PH_TITLE;
      end
      default: state_next = PH_TITLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PH_TITLE;
      turn_out      <= '0;
      player_hp_out <= PLAYER_MAX;
      enemy_hp_out  <= ENEMY_MAX;
      watchdog      <= '0;
      game_over_out <= 1'b0;
      win_out       <= 1'b0;
    end else begin
      state         <= state_next;
      turn_out      <= turn_next;
      player_hp_out <= php_next;
      enemy_hp_out  <= ehp_next;
      watchdog      <= wd_next;
      game_over_out <= (state_next == PH_LOSE);
      win_out       <= (state_next == PH_WIN);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_battle_controller.sv
// Testbench for battle_controller. A game-rules model predicts every output
// each cycle; directed sequences walk through start, fights, turn wrap,
// victory, defeat, spare, watchdog timeout, same-cycle hit/finish and reset
// in mid-phase, with literal expectations at key points.
module tb_battle_controller;
  import battle_pkg::*;

  localparam int PHP = 20, EHP = 30, HITD = 4, ATKD = 5, NT = 10, TMO = 16;
  localparam int IFR = 8;

  logic clk = 1'b0;
  logic rst, start_in, confirm_in, select_in, attack_done_in, attack_hit_in;
  logic enemy_busy_in, enemy_finished_in, damage_in;
  logic [3:0] state_out, turn_out;
  logic [7:0] player_hp_out, enemy_hp_out;
  logic game_over_out, win_out;

  int n_vec = 0;
  int n_err = 0;

  battle_controller #(
    .PLAYER_HP_MAX(PHP), .ENEMY_HP_MAX(EHP), .HIT_DMG(HITD), .ATTACK_DMG(ATKD),
    .NUM_TURNS(NT), .TIMEOUT_CYCLES(32'(TMO))
`ifdef BATTLE_IFRAME_EN
    , .IFRAME_CYCLES(32'(IFR))
`endif
  ) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .confirm_in(confirm_in),
    .select_in(select_in), .attack_done_in(attack_done_in),
    .attack_hit_in(attack_hit_in), .enemy_busy_in(enemy_busy_in),
    .enemy_finished_in(enemy_finished_in), .damage_in(damage_in),
    .state_out(state_out), .turn_out(turn_out),
    .player_hp_out(player_hp_out), .enemy_hp_out(enemy_hp_out),
    .game_over_out(game_over_out), .win_out(win_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game-rules model ----------------
  // Inputs change 2 time units after a rising edge, so the values seen on
  // the falling edge are exactly those the DUT samples on the next rising
  // edge. The model compares its current prediction, then advances one turn
  // of the rules using those inputs.
  int  m_phase, m_turn, m_php, m_ehp, m_enemy_cycles, m_cycle, m_last_hit;
  bit  m_valid = 0, m_has_hit;
  bit  p_start, p_confirm, p_damage;

  always @(negedge clk) begin
    bit s_edge, c_edge, d_edge, take_hit, leave;
    if (m_valid) begin
      check("state",     state_out,     m_phase);
      check("turn",      turn_out,      m_turn);
      check("player_hp", player_hp_out, m_php);
      check("enemy_hp",  enemy_hp_out,  m_ehp);
      check("game_over", game_over_out, m_phase == PH_LOSE);
      check("win",       win_out,       m_phase == PH_WIN);
    end
    s_edge = start_in && !p_start;
    c_edge = confirm_in && !p_confirm;
    d_edge = damage_in && !p_damage;
    m_cycle++;
    if (rst) begin
      m_phase = PH_TITLE; m_turn = 0; m_php = PHP; m_ehp = EHP;
      m_enemy_cycles = 0; m_has_hit = 0;
      p_start = 0; p_confirm = 0; p_damage = 0;
    end else begin
      case (m_phase)
        PH_TITLE: if (s_edge) begin
          m_phase = PH_MENU; m_php = PHP; m_ehp = EHP; m_turn = 0;
        end
        PH_MENU: if (c_edge) m_phase = select_in ? PH_WIN : PH_ATTACK;
        PH_ATTACK: if (attack_done_in) begin
          if (attack_hit_in) m_ehp = (m_ehp > ATKD) ? m_ehp - ATKD : 0;
          m_phase = (m_ehp == 0) ? PH_WIN : PH_ENEMY;
          m_enemy_cycles = 0; m_has_hit = 0;
        end
        PH_ENEMY: begin
          take_hit = d_edge;
`ifdef BATTLE_IFRAME_EN
          if (m_has_hit && (m_cycle - m_last_hit) < IFR) take_hit = 0;
`endif
          leave = enemy_finished_in ||
                  (m_enemy_cycles == TMO - 1 && enemy_busy_in);
          m_enemy_cycles++;
          if (take_hit) begin
            m_php = (m_php > HITD) ? m_php - HITD : 0;
            m_has_hit = 1; m_last_hit = m_cycle;
          end
          if (take_hit && m_php == 0) m_phase = PH_LOSE;
          else if (leave) begin
            m_phase = PH_MENU; m_turn = (m_turn + 1) % NT;
          end
        end
        default: if (s_edge) m_phase = PH_TITLE;  // LOSE, WIN
      endcase
      p_start = start_in; p_confirm = confirm_in; p_damage = damage_in;
    end
    m_valid = 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic press_start();
    start_in = 1; cyc(); start_in = 0; cyc();
  endtask

  // From MENU: choose FIGHT, then end the attack minigame.
  task automatic fight(input bit hit);
    select_in = 0; confirm_in = 1; cyc(); confirm_in = 0;
    attack_done_in = 1; attack_hit_in = hit; cyc();
    attack_done_in = 0; attack_hit_in = 0;
  endtask

  task automatic finish_enemy();
    enemy_finished_in = 1; cyc(); enemy_finished_in = 0;
  endtask

  // One damage rising edge, then enough quiet cycles to clear any
  // invulnerability window before the next one.
  task automatic hit_once();
    damage_in = 1; cyc(); damage_in = 0; cyc();
`ifdef BATTLE_IFRAME_EN
    cyc(IFR);
`endif
  endtask

  initial begin
    int n;
    rst = 1; start_in = 0; confirm_in = 0; select_in = 0; attack_done_in = 0;
    attack_hit_in = 0; enemy_busy_in = 0; enemy_finished_in = 0; damage_in = 0;
    cyc(3); rst = 0; cyc();

    // Reset state.
    check("rst_state", state_out, 4'b0000);
    check("rst_php", player_hp_out, 20);
    check("rst_ehp", enemy_hp_out, 30);
    check("rst_turn", turn_out, 0);

    // Start: one cycle to MENU.
    start_in = 1; cyc();
    check("start_menu", state_out, 4'b0001);
    start_in = 0; cyc();

    // Stray pulses in MENU are ignored; start in MENU does nothing.
    attack_done_in = 1; attack_hit_in = 1; enemy_finished_in = 1; damage_in = 1;
    cyc();
    attack_done_in = 0; attack_hit_in = 0; enemy_finished_in = 0; damage_in = 0;
    press_start();
    check("menu_ignore", state_out, 4'b0001);

    // First landed attack, then enemy phase finishes.
    fight(1);
    check("atk_ehp25", enemy_hp_out, 25);
    check("atk_enemy", state_out, 4'b1000);
    finish_enemy();
    check("fin_menu", state_out, 4'b0001);
    check("fin_turn1", turn_out, 1);

    // Nine more missed rounds: turn 1 -> 9 -> wraps to 0.
    for (int i = 0; i < 9; i++) begin
      fight(0); cyc(); finish_enemy();
      if (i == 7) check("turn9", turn_out, 9);
    end
    check("turn_wrap", turn_out, 0);

    // Five more landed attacks: sixth overall reaches 0 -> WIN.
    for (int i = 0; i < 5; i++) begin
      fight(1);
      if (i < 4) finish_enemy();
    end
    check("win_ehp0", enemy_hp_out, 0);
    check("win_flag", win_out, 1);
    check("win_state", state_out, 4'b1110);
    press_start();
    check("win_title", state_out, 4'b0000);

    // Five hits in one enemy phase -> LOSE on the cycle after the fifth.
    press_start(); fight(0);
    for (int i = 0; i < 5; i++) begin
      damage_in = 1; cyc();
      check("dmg_php", player_hp_out, 16 - 4 * i);
      damage_in = 0; cyc();
`ifdef BATTLE_IFRAME_EN
      if (i < 4) cyc(IFR);
`endif
    end
    check("lose_state", state_out, 4'b1100);
    check("lose_flag", game_over_out, 1);
    press_start();
    check("lose_title", game_over_out, 0);

`ifdef BATTLE_IFRAME_EN
    // Edges at t=0 and t=4 give one decrement; edge at t=10 gives another.
    press_start(); fight(0);
    for (int i = 0; i < 12; i++) begin
      damage_in = (i == 0 || i == 4 || i == 10); cyc();
      if (i == 4) check("iframe_16", player_hp_out, 16);
      if (i == 10) check("iframe_12", player_hp_out, 12);
    end
    damage_in = 0; finish_enemy();
    rst = 1; cyc(); rst = 0; cyc();
`endif

    // Watchdog: busy held, no finish -> MENU after TMO cycles in ENEMY.
    press_start(); fight(0);
    enemy_busy_in = 1; n = 0;
    while (state_out == 4'b1000 && n < 4 * TMO) begin cyc(); n++; end
    enemy_busy_in = 0;
    check("tmo_cycles", n, TMO);
    check("tmo_menu", state_out, 4'b0001);
    check("tmo_turn", turn_out, 1);

    // Non-lethal hit with a same-cycle finish -> damage applied, then MENU.
    fight(0);
    damage_in = 1; enemy_finished_in = 1; cyc();
    damage_in = 0; enemy_finished_in = 0;
    check("hitfin_php", player_hp_out, 16);
    check("hitfin_menu", state_out, 4'b0001);
    cyc();

    // Down to 4 HP, then a lethal hit with a same-cycle finish -> LOSE.
    fight(0);
    for (int i = 0; i < 3; i++) hit_once();
    check("pre_lethal", player_hp_out, 4);
    damage_in = 1; enemy_finished_in = 1; cyc();
    damage_in = 0; enemy_finished_in = 0;
    check("lethal_lose", state_out, 4'b1100);
    cyc();

    // SPARE from the menu goes straight to WIN.
    press_start(); press_start();
    select_in = 1; confirm_in = 1; cyc(); confirm_in = 0; select_in = 0;
    check("spare_win", state_out, 4'b1110);
    press_start();

    // Reset in mid-phase returns to TITLE the next cycle.
    press_start(); fight(0); damage_in = 1;
    rst = 1; cyc(); rst = 0; damage_in = 0;
    check("midrst_state", state_out, 4'b0000);
    check("midrst_php", player_hp_out, 20);
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
